// File: rtl/alu_issue_arbiter_if.sv
// Reservation-station, ALU and CDB signal bundle around the ALU issue arbiter.
// The arbiter takes the slave modport; the surrounding core (or bench) takes master.
interface alu_issue_arbiter_if #(
    parameter int NUM_RS    = 4,
    parameter int TAG_WIDTH = 3,
    parameter int DATA_W    = 16,
    parameter int ALUOP_W   = 3
);
    logic [NUM_RS-1:0]                rs_ready;
    logic [NUM_RS-1:0][ALUOP_W-1:0]   rs_aluop;
    logic [NUM_RS-1:0][DATA_W-1:0]    rs_opa;
    logic [NUM_RS-1:0][DATA_W-1:0]    rs_opb;
    logic [NUM_RS-1:0][TAG_WIDTH-1:0] rs_tag;
    logic [NUM_RS-1:0]                rs_grant;

    logic [ALUOP_W-1:0]               alu_op;
    logic [DATA_W-1:0]                alu_a;
    logic [DATA_W-1:0]                alu_b;
    logic [DATA_W-1:0]                alu_f;

    logic                             cdb_req;
    logic [TAG_WIDTH-1:0]             cdb_tag;
    logic [DATA_W-1:0]                cdb_data;
    logic                             cdb_ack;

    modport master (
        output rs_ready, rs_aluop, rs_opa, rs_opb, rs_tag, alu_f, cdb_ack,
        input  rs_grant, alu_op, alu_a, alu_b, cdb_req, cdb_tag, cdb_data
    );

    modport slave (
        input  rs_ready, rs_aluop, rs_opa, rs_opb, rs_tag, alu_f, cdb_ack,
        output rs_grant, alu_op, alu_a, alu_b, cdb_req, cdb_tag, cdb_data
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of ALU reservation-station entries into a two-stage
// execute (p1) / writeback (p2) pipe feeding the common data bus.
package lc3b_types;
    typedef enum logic [2:0] {
        alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
    } lc3b_aluop;
endpackage

module alu_issue_arbiter #(
    parameter int NUM_RS    = 4,
    parameter int TAG_WIDTH = 3,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    alu_issue_arbiter_if.slave bus
);
    import lc3b_types::*;

    localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic [PTR_W-1:0]     r_ptr;

    logic                 r_vld_p1;
    lc3b_aluop            r_op_p1;
    logic [DATA_W-1:0]    r_a_p1;
    logic [DATA_W-1:0]    r_b_p1;
    logic [TAG_WIDTH-1:0] r_tag_p1;

    logic                 r_vld_p2;
    logic [TAG_WIDTH-1:0] r_tag_p2;
    logic [DATA_W-1:0]    r_data_p2;

    logic                 w_wb_free;
    logic                 w_ex_adv;
    logic                 w_issue_ok;
    logic                 w_found;
    logic                 w_grant;
    logic [PTR_W-1:0]     w_idx;
    logic [PTR_W-1:0]     w_win;
    logic [PTR_W-1:0]     w_ptr_nxt;

    assign w_wb_free  = !r_vld_p2 || bus.cdb_ack;
    assign w_ex_adv   = r_vld_p1 && w_wb_free;
    // rst_n gates issue so no entry believes it was granted while the pipe is held in reset
    assign w_issue_ok = rst_n && (!r_vld_p1 || w_ex_adv) && !flush;
    assign w_grant    = w_issue_ok && w_found;

    // First ready entry at or after the pointer, wrapping past the top index
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NUM_RS);
            if (!w_found && bus.rs_ready[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_ptr_nxt = (int'(w_win) == NUM_RS - 1) ? '0 : w_win + 1'b1;

    always_comb begin
        bus.rs_grant = '0;
        if (w_grant) bus.rs_grant[w_win] = 1'b1;
    end

    assign bus.alu_op   = r_op_p1;
    assign bus.alu_a    = r_a_p1;
    assign bus.alu_b    = r_b_p1;
    assign bus.cdb_req  = r_vld_p2;
    assign bus.cdb_tag  = r_tag_p2;
    assign bus.cdb_data = r_data_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_vld_p1  <= 1'b0;
            r_op_p1   <= alu_pass;
            r_a_p1    <= '0;
            r_b_p1    <= '0;
            r_tag_p1  <= '0;
            r_vld_p2  <= 1'b0;
            r_tag_p2  <= '0;
            r_data_p2 <= '0;
        end else begin
            // issue -> execute (p1)
            if (w_grant) begin
                r_vld_p1 <= 1'b1;
                r_op_p1  <= lc3b_aluop'(bus.rs_aluop[w_win]);
                r_a_p1   <= bus.rs_opa[w_win];
                r_b_p1   <= bus.rs_opb[w_win];
                r_tag_p1 <= bus.rs_tag[w_win];
                r_ptr    <= w_ptr_nxt;
            end else if (w_ex_adv || flush) begin
                r_vld_p1 <= 1'b0;
            end

            // execute -> writeback (p2); a flush squashes rather than delivers
            if (w_ex_adv && !flush) begin
                r_vld_p2  <= 1'b1;
                r_tag_p2  <= r_tag_p1;
                r_data_p2 <= bus.alu_f;
            end else if (bus.cdb_ack || flush) begin
                r_vld_p2 <= 1'b0;
            end
        end
    end
endmodule
